// File: rtl/ifu_prefetch.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to instruction
// memory and buffers returned words in a small queue that feeds the decoder.
module ifu_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_inst,
    output logic [31:0] id_addr
);

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Handshakes: a request transfers on a cycle where imem_req_valid && imem_req_ready;
    // once raised, valid and addr hold until transfer, redirect or reset. Responses have
    // no ready and are always taken. Decode pops on id_valid && id_ready.

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [31:0]   r_inst_q [DEPTH];
    logic [31:0]   r_addr_q [DEPTH];

    logic [31:0]   w_redirect_pc;
    logic [CW:0]   w_inflight;
    logic          w_req_valid;
    logic          w_req_fire;
    logic          w_drop_rsp;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_outstanding_after_rsp;

    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;

    // Queued words and requests still in flight share one credit pool of DEPTH.
    assign w_inflight  = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req_valid = rst_n && !redirect && (w_inflight < DEPTH_W);
    assign w_req_fire  = w_req_valid && imem_req_ready;

    assign w_drop_rsp = imem_rsp_valid && (r_drop != '0);
    assign w_push     = imem_rsp_valid && (r_drop == '0) && !redirect;
    assign w_pop      = (r_count != '0) && id_ready && !redirect;

    assign w_outstanding_after_rsp = r_outstanding - CW'(imem_rsp_valid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else if (redirect) begin
            // Everything still in flight after this cycle belongs to the old path.
            r_fetch_pc    <= w_redirect_pc;
            r_rsp_pc      <= w_redirect_pc;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= w_outstanding_after_rsp;
            r_drop        <= w_outstanding_after_rsp;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            r_outstanding <= w_outstanding_after_rsp + CW'(w_req_fire);
            if (w_drop_rsp) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_inst_q[r_wr_ptr] <= imem_rsp_data;
            r_addr_q[r_wr_ptr] <= r_rsp_pc + 32'd4;
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;

    // Decode sees only registered queue state; empty presents a zero bubble.
    assign id_valid = (r_count != '0);
    assign id_inst  = id_valid ? r_inst_q[r_rd_ptr] : 32'h0;
    assign id_addr  = id_valid ? r_addr_q[r_rd_ptr] : 32'h0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && (r_count == DEPTH_C)));

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
        w_inflight <= DEPTH_W);

    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (r_outstanding != '0));

    a_drop_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_drop <= r_outstanding);

    a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (imem_req_valid && !imem_req_ready) |=>
            (redirect || (imem_req_valid && $stable(imem_req_addr))));

endmodule

// File: doc/ifu_prefetch.md
Name: ifu_prefetch

Overview:
- Instruction fetch stage that sits directly upstream of the decoder.
- Owns the fetch PC and issues word requests to instruction memory over a valid/ready handshake.
- Buffers returned words in a DEPTH-entry prefetch queue and presents one instruction per cycle to decode as {id_inst, id_addr}.
- id_addr follows the decoder convention: it is the instruction's PC+4 (auipc computes addr-4). On a branch/jump redirect it flushes the queue and discards in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, prefetch queue entries; also the credit limit on (queued + outstanding) requests; power of two, >=2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- redirect  input  1  branch/jump taken; flush and restart fetch.
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response word valid; always accepted, no ready; responses arrive in request order.
- imem_rsp_data  input  32  instruction word.
- id_valid  output  1  queue head valid.
- id_ready  input  1  decode consumes head.
- id_inst  output  32  head instruction; 32'h0 (decoder bubble) when id_valid=0.
- id_addr  output  32  head PC+4; 32'h0 when id_valid=0.

Behaviour:
- Clock and reset: one clock (clk); synchronous active-low reset (rst_n), sampled on the clk edge.
- Reset values: fetch_pc=RESET_PC, rsp_pc=RESET_PC, queue empty, outstanding=0, drop=0. Outputs: id_valid=0, id_inst=0, id_addr=0, imem_req_valid=0. Reset overrides every other input in the same cycle.
- Counter widths: count, outstanding and drop are $clog2(DEPTH)+1 bits. PC arithmetic is modulo 2^32 and wraps 0xFFFF_FFFC -> 0x0000_0000 silently.
- Request side:
  - imem_req_valid = !redirect && (count + outstanding) < DEPTH; imem_req_addr = fetch_pc.
  - Request fire (valid & ready): fetch_pc += 4 and outstanding++.
  - When not fired, fetch_pc and addr are held stable. Once valid is asserted it may drop only on redirect or reset.
- Response side: each imem_rsp_valid decrements outstanding.
  - If drop>0: decrement drop and discard the word.
  - Otherwise push {imem_rsp_data, rsp_pc+4} and advance rsp_pc by 4.
- Output side: id_valid = (count != 0), driven from queue registers with no combinational path from imem_rsp_*.
  - A response in cycle N is visible at decode in cycle N+1.
  - Pop on id_valid & id_ready; id_ready is ignored when empty.
  - Push and pop in the same cycle are allowed at any occupancy, including full. The credit rule guarantees no overflow; overflow is an assertion failure.
- Throughput: sustained 1 instruction/cycle with 1-cycle memory latency and id_ready=1.
- Redirect (priority over everything except reset), in the same cycle:
  - imem_req_valid=0; queue cleared; any pop is ignored.
  - Any imem_rsp that cycle is discarded.
  - fetch_pc and rsp_pc load {redirect_pc[31:2],2'b00}.
  - drop and outstanding both load outstanding - imem_rsp_valid.
- After a redirect:
  - Next cycle: id_valid=0, id_inst=0, and new requests may issue.
  - A redirect while drop>0 accumulates correctly, because drop is reloaded from outstanding.
- Credits: stale in-flight responses still consume credits until they return.

Test Plan:
- Reset then run, RESET_PC=0, 1-cycle memory returning data=0x1000_0000|addr, id_ready=1 -> first id_valid 2 cycles after the first request fire (id_inst=0x1000_0000, id_addr=0x4), then one instruction per cycle with id_addr 0x8, 0xC, ...
- Backpressure, id_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 request fires, then imem_req_valid=0. On release, 4 in-order pops of addrs 0x0..0xC, then streaming resumes from 0x10 with no gaps or duplicates.
- Redirect to 0x100 with 2 outstanding on a 3-cycle-latency memory -> the next 2 responses are discarded. First delivered: id_addr=0x104, inst=0x1000_0100.
- Redirect in the same cycle as imem_rsp_valid and id_ready -> that word is dropped, no pop is counted, and the next cycle has id_valid=0, id_inst=0; the next request address is redirect_pc.
- imem_req_ready=0 for 5 cycles -> imem_req_valid stays 1 with imem_req_addr stable; fetch_pc is not advanced and outstanding is unchanged.
- Misaligned redirect_pc=0x103 -> imem_req_addr=0x100. Separately, rst_n=0 for one cycle with a full queue -> id_valid=0, id_inst=0, id_addr=0, and the next request is to RESET_PC.
